pixel_frame_writer: RTL and testbench

//   Sink end of the valid/ready pixel stream produced by convolution_filter (y_valid/y_ready/y_data).

---
 rtl/pixel_frame_writer.sv | 129 ++++++++++++
 tb/tb_pixel_frame_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_writer.sv
// Purpose: sink for a valid/ready pixel stream; writes one raster frame per start into a framebuffer port.
// Latency: accept -> mem_we is 1 cycle; 1 pixel/clk sustained while mem_ready stays high.
// Backpressure: x_ready drops while a write is stalled (mem_we && !mem_ready) and outside RUN.
//
// Ports:
//   clk, rst_n                    clock and synchronous active-low reset
//   start, abort                  begin a frame capture (IDLE only) / cancel the capture in flight
//   x_valid, x_ready, x_data      upstream pixel stream
//   mem_we, mem_addr, mem_wdata   framebuffer write request, retired when mem_we && mem_ready
//   mem_ready                     framebuffer accepts the write this cycle
//   busy, frame_done              capture in progress / one-cycle pulse once the last pixel is written
//   pixel_count                   pixels accepted in the current or most recent frame
module pixel_frame_writer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int W          = 8,
  parameter int ADDR_W     = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [W-1:0]      x_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [W-1:0]      mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W:0]   pixel_count
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic accept;
  logic retire;
  logic last_accept;

  assign accept      = x_valid && x_ready;
  assign retire      = mem_we && mem_ready;
  assign last_accept = accept && (pixel_count == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort outranks start and accept
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = RUN;
      RUN: begin
        if (abort)            state_nxt = IDLE;
        else if (last_accept) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (abort)       state_nxt = IDLE;
        else if (retire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state. The single output register can take a new pixel
  // whenever it is empty or being drained this cycle; x_valid is deliberately
  // not part of this term.
  always_comb begin
    x_ready = (state == RUN) && (!mem_we || mem_ready);
    busy    = (state != IDLE);
  end

  // Write register, pixel counter and completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) pixel_count <= '0;
        end
        RUN: begin
          if (abort) begin
            // Pending write is dropped; pixel_count keeps what was accepted.
            mem_we <= 1'b0;
          end else if (accept) begin
            // Refill (possibly in the same cycle the previous write retires).
            mem_we      <= 1'b1;
            mem_addr    <= pixel_count[ADDR_W-1:0];
            mem_wdata   <= x_data;
            pixel_count <= pixel_count + 1'b1;
          end else if (retire) begin
            mem_we <= 1'b0;
          end
        end
        FLUSH: begin
          if (abort) begin
            mem_we <= 1'b0;
          end else if (retire) begin
            mem_we     <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_writer.sv
module tb_pixel_frame_writer;

  localparam int IW = 4;
  localparam int IH = 3;
  localparam int NPX = IW * IH;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, x_valid, x_ready, mem_we, mem_ready, busy, frame_done;
  logic [7:0] x_data, mem_wdata;
  logic [3:0] mem_addr;
  logic [4:0] pixel_count;

  pixel_frame_writer #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .frame_done(frame_done), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  writes_seen = 0;
  int  done_cnt = 0;
  int  wr_base = 0;
  int  first_wr_cyc = 0;
  int  last_wr_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every retired write, checks hold-while-stalled
  // and the spacing between the final write and frame_done.
  initial begin : monitor
    bit         stall_pend = 1'b0;
    logic [3:0] stall_addr = '0;
    logic [7:0] stall_data = '0;
    wr_t        e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_pend && mem_we) begin
          chk("held_addr", int'(mem_addr), int'(stall_addr));
          chk("held_data", int'(mem_wdata), int'(stall_data));
        end
        stall_pend = mem_we && !mem_ready;
        stall_addr = mem_addr;
        stall_data = mem_wdata;
        if (frame_done) begin
          done_cnt++;
          chk("done_after_last_write", cyc - last_wr_cyc, 1);
        end
        if (mem_we && mem_ready) begin
          if (writes_seen == wr_base) first_wr_cyc = cyc;
          last_wr_cyc = cyc;
          writes_seen++;
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", int'(mem_addr), int'(e.a));
            chk("wr_data", int'(mem_wdata), int'(e.d));
          end
        end
      end else begin
        stall_pend = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offers pixels 0x10+i until n have been accepted. gap_pct/mr_pct give the
  // chance of dropping x_valid / mem_ready; stall_at forces three mem_ready-low
  // cycles while that address is being written.
  task automatic feed(input int n, input int gap_pct, input int mr_pct, input int stall_at);
    int   idx = 0;
    int   guard = 0;
    int   stalls = 0;
    bit   stalled;
    wr_t  e;
    while (idx < n && guard < 500) begin
      stalled = 1'b0;
      x_valid = (gap_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap_pct);
      x_data  = 8'h10 + 8'(idx);
      if (stall_at >= 0 && mem_we && int'(mem_addr) == stall_at && stalls < 3) begin
        mem_ready = 1'b0;
        stalled   = 1'b1;
        stalls++;
      end else begin
        mem_ready = (mr_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= mr_pct);
      end
      @(negedge clk);
      if (stalled) chk("stall_x_ready_low", int'(x_ready), 0);
      if (x_valid && x_ready) begin
        e.a = 4'(idx);
        e.d = 8'h10 + 8'(idx);
        exp_q.push_back(e);
        idx++;
      end
      step();
      guard++;
    end
    x_valid = 1'b0;
    if (guard >= 500) chk("feed_timeout", idx, n);
    if (stall_at >= 0) chk("stall_cycles", stalls, 3);
  endtask

  task automatic wait_done(input int d0);
    int guard = 0;
    mem_ready = 1'b1;
    x_valid   = 1'b0;
    while (done_cnt == d0 && guard < 40) begin
      step();
      guard++;
    end
    if (guard >= 40) chk("frame_done_timeout", done_cnt - d0, 1);
    @(negedge clk);
  endtask

  task automatic full_frame(input string tag, input int gap_pct, input int mr_pct, input int stall_at);
    int d0;
    d0 = done_cnt;
    wr_base = writes_seen;
    pulse_start();
    feed(NPX, gap_pct, mr_pct, stall_at);
    wait_done(d0);
    chk({tag, "_writes"}, writes_seen - wr_base, NPX);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_pixel_count"}, int'(pixel_count), NPX);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    x_valid = 1'b0; x_data = '0; mem_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_x_ready", int'(x_ready), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_pixel_count", int'(pixel_count), 0);
    step();

    // 1: full-rate frame, writes on consecutive clocks
    full_frame("t1", 0, 0, -1);
    chk("t1_write_span", last_wr_cyc - first_wr_cyc, NPX - 1);
    step();

    // 2: framebuffer stall while writing pixel 5
    full_frame("t2", 0, 0, 5);
    step();

    // 3: random source gaps and random framebuffer readiness
    full_frame("t3", 40, 50, -1);
    step();

    // 4: abort with pixel 6 pending, then a fresh frame
    d0 = done_cnt;
    pulse_start();
    feed(7, 0, 0, -1);
    mem_ready = 1'b0;
    abort     = 1'b1;
    @(negedge clk);
    chk("t4_pending_before_abort", exp_q.size(), 1);
    step();
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t4_busy", int'(busy), 0);
    chk("t4_mem_we", int'(mem_we), 0);
    chk("t4_pixel_count", int'(pixel_count), 7);
    mem_ready = 1'b1;
    repeat (3) step();
    chk("t4_no_done", done_cnt - d0, 0);
    full_frame("t4_restart", 0, 0, -1);
    step();

    // 5: source valid while idle, then start together with abort
    wr_base = writes_seen;
    x_valid = 1'b1;
    x_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_idle_x_ready", int'(x_ready), 0);
      step();
    end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("t5_start_abort_busy", int'(busy), 0);
    chk("t5_start_abort_x_ready", int'(x_ready), 0);
    chk("t5_no_writes", writes_seen - wr_base, 0);
    x_valid = 1'b0;
    step();

    // 6: reset with pixel 8 pending
    d0 = done_cnt;
    pulse_start();
    feed(9, 0, 0, -1);
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    exp_q.delete();
    @(negedge clk);
    chk("t6_x_ready", int'(x_ready), 0);
    chk("t6_mem_we", int'(mem_we), 0);
    chk("t6_mem_addr", int'(mem_addr), 0);
    chk("t6_mem_wdata", int'(mem_wdata), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_pixel_count", int'(pixel_count), 0);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    repeat (4) step();
    chk("t6_no_done", done_cnt - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
